// File: rtl/irq_controller.sv
// ---------------------------------------------------------------------------
// irq_controller
//   Interrupt controller in front of the trap/CSR exception unit. Collects
//   N_SRC interrupt lines with per-source enable, trigger mode (edge/level)
//   and pending state, picks one winner, raises irq_out with irq_id, and runs
//   a claim (irq_ack) / complete (irq_complete) handshake. One interrupt is
//   in flight at a time; there is no nesting.
//
//   Build option: define IRQ_ROUND_ROBIN_EN to arbitrate round-robin from
//   rr_ptr instead of fixed lowest-index priority.
//
// Ports
//   clk           clock, all state updates on posedge
//   rst_n         asynchronous active-low reset
//   src_irq       raw interrupt lines, synchronous to clk
//   cfg_we        config write strobe
//   cfg_addr      0 enable, 1 edge_mode, 2 pending (W1C), 3 status (RO)
//   cfg_wdata     config write data, bits [N_SRC-1:0] used
//   cfg_rdata     combinational read of cfg_addr
//                 status = {in_service[31], zeros, irq_id[ID_W-1:0]}
//   irq_out       interrupt request to the exception unit
//   irq_id        ID of the requested / in-service source
//   irq_ack       pulse: trap taken
//   irq_complete  pulse: handler finished (mret)
// ---------------------------------------------------------------------------
module irq_controller #(
    parameter int N_SRC = 8,
    parameter int ID_W  = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_SRC-1:0] src_irq,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_addr,
    input  logic [31:0]      cfg_wdata,
    output logic [31:0]      cfg_rdata,
    output logic             irq_out,
    output logic [ID_W-1:0]  irq_id,
    input  logic             irq_ack,
    input  logic             irq_complete
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_SERVICE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [N_SRC-1:0] r_enable;
    logic [N_SRC-1:0] r_edge;
    logic [N_SRC-1:0] r_pending;
    logic [N_SRC-1:0] r_src_prev;
    logic [ID_W-1:0]  r_irq_id;

    logic [N_SRC-1:0] w_eligible;
    logic [N_SRC-1:0] w_id_mask;
    logic [N_SRC-1:0] w_rise;
    logic [N_SRC-1:0] w_w1c;
    logic [N_SRC-1:0] w_ack_clr;
    logic [N_SRC-1:0] w_pending_nxt;
    logic [ID_W-1:0]  w_winner;
    logic             w_any;
    logic             w_cur_elig;
    logic             w_take_ack;
    logic             w_unused_wdata;

    // Upper write-data bits are architecturally ignored.
    assign w_unused_wdata = ^cfg_wdata;

    assign w_eligible = r_pending & r_enable;
    assign w_any      = |w_eligible;
    assign w_id_mask  = N_SRC'(1) << r_irq_id;
    assign w_cur_elig = |(w_eligible & w_id_mask);
    assign w_take_ack = (r_state == S_REQ) && irq_ack;

    // Edge sources: a fresh rising edge beats any clear in the same cycle.
    // Level sources simply track the line.
    assign w_rise        = src_irq & ~r_src_prev;
    assign w_w1c         = (cfg_we && cfg_addr == 2'd2) ? cfg_wdata[N_SRC-1:0] : '0;
    assign w_ack_clr     = w_take_ack ? w_id_mask : '0;
    assign w_pending_nxt = (r_edge & (w_rise | (r_pending & ~(w_w1c | w_ack_clr))))
                         | (~r_edge & src_irq);

`ifdef IRQ_ROUND_ROBIN_EN
    logic [ID_W-1:0] r_rr_ptr;
    logic [ID_W-1:0] w_win_hi;
    logic [ID_W-1:0] w_win_lo;
    logic            w_hi_found;

    // Lowest eligible index at/after rr_ptr, else lowest overall (wrap).
    always_comb begin
        w_win_hi   = '0;
        w_win_lo   = '0;
        w_hi_found = 1'b0;
        for (int k = N_SRC - 1; k >= 0; k--) begin
            if (w_eligible[k]) begin
                w_win_lo = ID_W'(k);
                if (k >= int'(r_rr_ptr)) begin
                    w_win_hi   = ID_W'(k);
                    w_hi_found = 1'b1;
                end
            end
        end
        w_winner = w_hi_found ? w_win_hi : w_win_lo;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= '0;
        end else if (w_take_ack) begin
            r_rr_ptr <= (r_irq_id == ID_W'(N_SRC - 1)) ? '0 : r_irq_id + ID_W'(1);
        end
    end
`else
    // Fixed priority: scanning downward leaves the lowest index.
    always_comb begin
        w_winner = '0;
        for (int k = N_SRC - 1; k >= 0; k--) begin
            if (w_eligible[k]) w_winner = ID_W'(k);
        end
    end
`endif

    // Source state and config registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_enable   <= '0;
            r_edge     <= '0;
            r_pending  <= '0;
            r_src_prev <= '0;
        end else begin
            r_src_prev <= src_irq;
            r_pending  <= w_pending_nxt;
            if (cfg_we && cfg_addr == 2'd0) r_enable <= cfg_wdata[N_SRC-1:0];
            if (cfg_we && cfg_addr == 2'd1) r_edge   <= cfg_wdata[N_SRC-1:0];
        end
    end

    // ID is latched only on arbitration in IDLE, held through REQ/SERVICE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_irq_id <= '0;
        end else if (r_state == S_IDLE && w_any) begin
            r_irq_id <= w_winner;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        irq_out     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any) w_state_nxt = S_REQ;
            end
            S_REQ: begin
                irq_out = 1'b1;
                // ack wins over a simultaneous drop of the request
                if (irq_ack)          w_state_nxt = S_SERVICE;
                else if (!w_cur_elig) w_state_nxt = S_IDLE;
            end
            S_SERVICE: begin
                if (irq_complete) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign irq_id = r_irq_id;

    always_comb begin
        cfg_rdata = '0;
        case (cfg_addr)
            2'd0: cfg_rdata[N_SRC-1:0] = r_enable;
            2'd1: cfg_rdata[N_SRC-1:0] = r_edge;
            2'd2: cfg_rdata[N_SRC-1:0] = r_pending;
            default: begin
                cfg_rdata[31]       = (r_state == S_SERVICE);
                cfg_rdata[ID_W-1:0] = r_irq_id;
            end
        endcase
    end

endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Interrupt controller that sits in front of the trap/CSR exception unit.
- Collects N_SRC external interrupt lines and holds per-source enable, trigger-mode and pending state.
- Selects one winner, drives the single interrupt request line plus a source ID, and sequences a claim (trap taken) / complete (mret) handshake.
- Only one interrupt is in flight at a time; no nesting.

Parameters:
- N_SRC, 8, number of interrupt sources (1..32).
- ID_W, 3, width of source ID; must satisfy 2**ID_W >= N_SRC.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst_n  input  1  reset, asynchronous, active-low.
- src_irq  input  N_SRC  raw interrupt lines, already synchronous to clk.
- cfg_we  input  1  config write strobe.
- cfg_addr  input  2  config register select: 0 enable, 1 edge_mode, 2 pending (W1C), 3 status.
- cfg_wdata  input  32  config write data; bits [N_SRC-1:0] used.
- cfg_rdata  output  32  combinational read of cfg_addr; status reads {in_service at bit 31, zeros, irq_id at [ID_W-1:0]}.
- irq_out  output  1  interrupt request to the exception unit.
- irq_id  output  ID_W  ID of the requested or in-service source.
- irq_ack  input  1  one-cycle pulse: exception unit has taken the interrupt trap.
- irq_complete  input  1  one-cycle pulse: handler finished (mret).

Behaviour:
- Reset (rst_n=0, asynchronous) clears enable, edge_mode, pending, src_prev and rr_ptr to 0, sets state IDLE, and drives irq_out=0, irq_id=0.
- Edge-mode source (edge_mode[i]=1):
  - pending[i] is set at a posedge where src_irq[i]=1 and src_prev[i]=0.
  - It clears on ack of source i or on a cfg W1C write (cfg_addr=2, cfg_wdata[i]=1).
  - A set and a clear in the same cycle: set wins.
- Level-mode source: pending[i] <= src_irq[i] every cycle; W1C writes and ack have no effect on it.
- src_prev <= src_irq every cycle.
- eligible = pending & enable.
- Winner is the lowest-index eligible bit (fixed priority).
- FSM states IDLE, REQ, SERVICE:
  - IDLE: irq_out=0. If eligible != 0, latch the winner into irq_id and go to REQ. irq_out rises the cycle after pending is visible, so src_irq is sampled high at posedge k and irq_out=1 after posedge k+1.
  - REQ: irq_out=1 and irq_id is held stable; no re-arbitration.
    - On irq_ack: go to SERVICE; clear pending[irq_id] if edge mode.
    - Else, if eligible[irq_id]=0 (level dropped, disabled, or W1C): go to IDLE, so irq_out=0 next cycle.
    - ack takes precedence over the drop.
  - SERVICE: irq_out=0, irq_id held. On irq_complete go to IDLE. New pending events keep accumulating.
- Ignored inputs: irq_ack in IDLE or SERVICE; irq_complete in IDLE or REQ. If ack and complete arrive together in REQ, go to SERVICE only.
- Config writes take effect at the posedge. A write to addr 3 is ignored. Bits at or above N_SRC read as 0.
- Asserting rst_n low mid-handshake returns to IDLE immediately; any in-service state is lost.

Optional Feature:
- IRQ_ROUND_ROBIN_EN defined:
  - Winner is the first eligible index at or after rr_ptr, wrapping modulo N_SRC.
  - On irq_ack, rr_ptr <= irq_id+1, wrapping N_SRC-1 to 0.
- IRQ_ROUND_ROBIN_EN undefined: fixed lowest-index priority; rr_ptr is absent.

Test Plan:
- Reset then enable=0x01, edge=0x01; pulse src_irq[0] for 1 cycle -> irq_out=1 two cycles after the sampled edge, irq_id=0; ack -> irq_out=0, pending=0x00; complete -> IDLE, status bit31=0.
- enable=0x0C, level mode; hold src_irq[2] and src_irq[3] high -> irq_id=2 (fixed priority); with IRQ_ROUND_ROBIN_EN, after ack+complete of 2 the next request has irq_id=3.
- Level src_irq[5] enabled; deassert before ack -> irq_out falls next cycle, FSM in IDLE, no SERVICE entry.
- Edge source 1 pending; cfg W1C of bit 1 in the same cycle as a new rising edge on src_irq[1] -> pending[1] stays 1.
- Source 4 in SERVICE; pulse edge src_irq[4] again and issue a spurious ack -> no change; after complete -> irq_out=1 with irq_id=4 next cycle.
- Assert rst_n low while in REQ -> irq_out=0 and irq_id=0 immediately (asynchronous); enable and pending read 0 after release.
